// File: rtl/qspi_mem_responder_if.sv
// QSPI bus between the flash/PSRAM controller (master) and the memory responder (slave).
interface qspi_mem_responder_if;
    logic       spi_cs_n;
    logic [3:0] spi_data_in;
    logic [3:0] spi_data_out;
    logic [3:0] spi_data_oe;

    modport master (
        output spi_cs_n,
        output spi_data_in,
        input  spi_data_out,
        input  spi_data_oe
    );

    modport slave (
        input  spi_cs_n,
        input  spi_data_in,
        output spi_data_out,
        output spi_data_oe
    );
endinterface

// File: rtl/qspi_mem_responder.sv
// Synthesizable QSPI flash (EBh) / PSRAM (35h, 0Bh, 02h) target, one beat per clk while selected.
// Optional macro QSPI_RESP_BURST_WRAP_EN: data-phase address wraps inside an aligned PAGE_BYTES block.
module qspi_mem_responder #(
    parameter int IS_ROM     = 0,
    parameter int ADDR_BITS  = 24,
    parameter int MEM_BYTES  = 256,
    parameter int PAGE_BYTES = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    qspi_mem_responder_if.slave          spi,
    input  logic                         load_en,
    input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
    input  logic [7:0]                   load_data,
    output logic                         quad_mode,
    output logic                         cmd_err,
    output logic [15:0]                  txn_count
);
    localparam int AW          = $clog2(MEM_BYTES);
    localparam int ADDR_BEATS  = ADDR_BITS / 4;
    localparam int DUMMY_BEATS = (IS_ROM != 0) ? 6 : 4;

    if (((MEM_BYTES & (MEM_BYTES - 1)) != 0) || (PAGE_BYTES > MEM_BYTES) || (ADDR_BITS < 4))
    begin : g_bad_cfg
        $error("qspi_mem_responder: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    state_t        state;
    logic [7:0]    bcnt;
    logic [6:0]    cmd_sr;
    logic [AW-1:0] addr;       // address shifter during ADDR, data pointer afterwards
    logic          nib_lo;     // next data beat is a low nibble
    logic [3:0]    wr_hi;
    logic          is_write;
    logic          active;     // at least one beat seen in this select window

    logic [7:0]    mem [MEM_BYTES];

    logic          cmd_quad;
    logic [7:0]    cmd_next;
    logic          cmd_last;
    logic [AW-1:0] addr_next;
    logic [AW-1:0] addr_inc;
    logic [7:0]    rd_byte;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

`ifdef QSPI_RESP_BURST_WRAP_EN
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cmd_quad  = (IS_ROM == 0) && quad_mode;
        cmd_next  = cmd_quad ? {cmd_sr[3:0], spi.spi_data_in} : {cmd_sr, spi.spi_data_in[0]};
        cmd_last  = cmd_quad ? (bcnt == 8'd1) : (bcnt == 8'd7);
        addr_next = AW'({addr, spi.spi_data_in});
`ifdef QSPI_RESP_BURST_WRAP_EN
        addr_inc  = (addr & ~PAGE_MASK) | ((addr + AW'(1)) & PAGE_MASK);
`else
        addr_inc  = addr + AW'(1);
`endif
        rd_byte   = mem[addr];

        mem_we    = 1'b0;
        mem_waddr = load_addr;
        mem_wdata = load_data;
        if (!rst && !spi.spi_cs_n && state == S_WDATA && nib_lo) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = {wr_hi, spi.spi_data_in};
        end else if (spi.spi_cs_n && load_en) begin
            mem_we    = 1'b1;
        end
    end

    // NOTE: the backing array has no reset so contents survive rst and it can map to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            spi.spi_data_out <= 4'h0;
            spi.spi_data_oe  <= 4'h0;
            quad_mode        <= 1'b0;
            cmd_err          <= 1'b0;
            txn_count        <= 16'h0;
            active           <= 1'b0;
            bcnt             <= 8'd0;
            nib_lo           <= 1'b0;
            is_write         <= 1'b0;
        end else if (spi.spi_cs_n) begin
            state           <= S_IDLE;
            spi.spi_data_oe <= 4'h0;
            bcnt            <= 8'd0;
            nib_lo          <= 1'b0;
            if (active) begin
                txn_count <= txn_count + 16'd1;
                active    <= 1'b0;
            end
        end else begin
            active          <= 1'b1;
            spi.spi_data_oe <= 4'h0;
            case (state)
                S_IDLE, S_CMD: begin
                    cmd_sr <= cmd_next[6:0];
                    bcnt   <= bcnt + 8'd1;
                    state  <= S_CMD;
                    if (cmd_last) begin
                        bcnt <= 8'd0;
                        if (IS_ROM != 0) begin
                            is_write <= 1'b0;
                            if (cmd_next == 8'hEB) begin
                                state <= S_ADDR;
                            end else begin
                                cmd_err <= 1'b1;
                                state   <= S_IGNORE;
                            end
                        end else if (!quad_mode) begin
                            if (cmd_next == 8'h35) quad_mode <= 1'b1;
                            else                   cmd_err   <= 1'b1;
                            state <= S_IGNORE;
                        end else begin
                            case (cmd_next)
                                8'h0B: begin is_write <= 1'b0; state <= S_ADDR; end
                                8'h02: begin is_write <= 1'b1; state <= S_ADDR; end
                                default: begin cmd_err <= 1'b1; state <= S_IGNORE; end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    addr <= addr_next;
                    bcnt <= bcnt + 8'd1;
                    if (bcnt == 8'(ADDR_BEATS - 1)) begin
                        bcnt   <= 8'd0;
                        nib_lo <= 1'b0;
                        state  <= is_write ? S_WDATA : S_DUMMY;
                    end
                end
                S_DUMMY: begin
                    bcnt <= bcnt + 8'd1;
                    // First high nibble goes out on the edge that ends DUMMY.
                    if (bcnt == 8'(DUMMY_BEATS - 1)) begin
                        bcnt             <= 8'd0;
                        spi.spi_data_out <= rd_byte[7:4];
                        spi.spi_data_oe  <= 4'hF;
                        nib_lo           <= 1'b1;
                        state            <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    spi.spi_data_oe <= 4'hF;
                    if (nib_lo) begin
                        spi.spi_data_out <= rd_byte[3:0];
                        addr             <= addr_inc;
                        nib_lo           <= 1'b0;
                    end else begin
                        spi.spi_data_out <= rd_byte[7:4];
                        nib_lo           <= 1'b1;
                    end
                end
                S_WDATA: begin
                    // Byte commits on its low nibble; a lone high nibble is dropped at deselect.
                    if (!nib_lo) begin
                        wr_hi  <= spi.spi_data_in;
                        nib_lo <= 1'b1;
                    end else begin
                        addr   <= addr_inc;
                        nib_lo <= 1'b0;
                    end
                end
                S_IGNORE: ;
                default: state <= S_IGNORE;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench: a flash-personality and a PSRAM-personality responder on separate selects.
module tb_qspi_mem_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs_rom = 1'b1;
    logic       cs_ram = 1'b1;
    logic [3:0] din = 4'h0;
    logic       load_en = 1'b0;
    logic [7:0] load_addr = 8'h0;
    logic [7:0] load_data = 8'h0;
    logic        rom_quad, rom_err, ram_quad, ram_err;
    logic [15:0] rom_cnt, ram_cnt;

    int  tests = 0;
    int  fails = 0;
    bit  use_rom;
    logic [3:0] oe_seen;

    always #5 clk = ~clk;

    qspi_mem_responder_if rom_if ();
    qspi_mem_responder_if ram_if ();
    assign rom_if.spi_cs_n    = cs_rom;
    assign rom_if.spi_data_in = din;
    assign ram_if.spi_cs_n    = cs_ram;
    assign ram_if.spi_data_in = din;

    qspi_mem_responder #(.IS_ROM(1)) u_rom (
        .clk(clk), .rst(rst), .spi(rom_if.slave),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .quad_mode(rom_quad), .cmd_err(rom_err), .txn_count(rom_cnt)
    );
    qspi_mem_responder #(.IS_ROM(0)) u_ram (
        .clk(clk), .rst(rst), .spi(ram_if.slave),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .quad_mode(ram_quad), .cmd_err(ram_err), .txn_count(ram_cnt)
    );

    typedef struct {
        bit          rom;
        logic [23:0] addr;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [3:0] cur_oe();
        return use_rom ? rom_if.spi_data_oe : ram_if.spi_data_oe;
    endfunction
    function automatic logic [3:0] cur_out();
        return use_rom ? rom_if.spi_data_out : ram_if.spi_data_out;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [3:0] d);
        if (use_rom) cs_rom = 1'b0; else cs_ram = 1'b0;
        din = d;
        @(posedge clk); #1;
        oe_seen = oe_seen | cur_oe();
    endtask

    task automatic end_txn();
        cs_rom = 1'b1;
        cs_ram = 1'b1;
        din    = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic send_single(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) beat({3'b000, b[i]});
    endtask
    task automatic send_quad(input logic [7:0] b);
        beat(b[7:4]);
        beat(b[3:0]);
    endtask
    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) beat(a[i*4 +: 4]);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic read_txn(input bit rom, input logic [23:0] a, output logic [15:0] data,
                            output logic [3:0] pre_oe, output logic [3:0] oe_and);
        use_rom = rom;
        oe_seen = 4'h0;
        if (rom) send_single(8'hEB); else send_quad(8'h0B);
        send_addr(a);
        repeat ((rom ? 6 : 4) - 1) beat(4'h0);
        pre_oe = oe_seen;
        data   = 16'h0;
        oe_and = 4'hF;
        for (int i = 0; i < 4; i++) begin
            beat(4'h0);
            data   = {data[11:0], cur_out()};
            oe_and = oe_and & cur_oe();
        end
        end_txn();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] data;
        logic [3:0]  pre_oe, oe_and;

        vecs[0] = '{rom: 1'b1, addr: 24'h000010, exp: 16'hA53C};
`ifdef QSPI_RESP_BURST_WRAP_EN
        vecs[1] = '{rom: 1'b1, addr: 24'h0000FF, exp: 16'hE1C3};
        vecs[2] = '{rom: 1'b0, addr: 24'h00001F, exp: 16'h967D};
`else
        vecs[1] = '{rom: 1'b1, addr: 24'h0000FF, exp: 16'hE17D};
        vecs[2] = '{rom: 1'b0, addr: 24'h00001F, exp: 16'h964B};
`endif
        vecs[3] = '{rom: 1'b0, addr: 24'h000040, exp: 16'h1234};
        vecs[4] = '{rom: 1'b0, addr: 24'h000105, exp: 16'h7822};
        vecs[5] = '{rom: 1'b1, addr: 24'hABCD20, exp: 16'h4B5A};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset ram oe",   {28'h0, ram_if.spi_data_oe}, 32'h0);
        check("reset ram out",  {28'h0, ram_if.spi_data_out}, 32'h0);
        check("reset rom oe",   {28'h0, rom_if.spi_data_oe}, 32'h0);
        check("reset quad",     {31'h0, ram_quad}, 32'h0);
        check("reset cmd_err",  {30'h0, ram_err, rom_err}, 32'h0);
        check("reset txn",      {rom_cnt, ram_cnt}, 32'h0);

        load(8'h10, 8'hA5); load(8'h11, 8'h3C); load(8'hFF, 8'hE1); load(8'h00, 8'h7D);
        load(8'hE0, 8'hC3); load(8'h1F, 8'h96); load(8'h20, 8'h4B); load(8'h21, 8'h5A);
        load(8'h05, 8'h11); load(8'h06, 8'h22); load(8'h40, 8'h00); load(8'h41, 8'h00);

        // Flash read
        read_txn(1'b1, 24'h000010, data, pre_oe, oe_and);
        check("flash data", {16'h0, data}, 32'h0000A53C);
        check("flash oe before data", {28'h0, pre_oe}, 32'h0);
        check("flash oe during data", {28'h0, oe_and}, 32'hF);
        check("flash oe after deselect", {28'h0, rom_if.spi_data_oe}, 32'h0);
        check("flash txn_count", {16'h0, rom_cnt}, 32'd1);

        // Enter quad mode
        use_rom = 1'b0;
        oe_seen = 4'h0;
        send_single(8'h35);
        end_txn();
        check("enter quad", {31'h0, ram_quad}, 32'h1);
        check("enter quad no err", {31'h0, ram_err}, 32'h0);
        check("enter quad txn", {16'h0, ram_cnt}, 32'd1);

        // Quad write of 12h 34h to 0x40
        oe_seen = 4'h0;
        send_quad(8'h02);
        send_addr(24'h000040);
        beat(4'h1); beat(4'h2); beat(4'h3); beat(4'h4);
        end_txn();
        check("write oe", {28'h0, oe_seen}, 32'h0);

        read_txn(1'b0, 24'h000040, data, pre_oe, oe_and);
        check("ram readback", {16'h0, data}, 32'h00001234);

        // Unsupported quad command followed by junk beats
        oe_seen = 4'h0;
        send_quad(8'h9F);
        repeat (10) beat(4'hA);
        end_txn();
        check("bad cmd oe", {28'h0, oe_seen}, 32'h0);
        check("bad cmd err", {31'h0, ram_err}, 32'h1);
        check("bad cmd txn", {16'h0, ram_cnt}, 32'd4);

        // Partial write: 78h committed, trailing 9 discarded
        send_quad(8'h02);
        send_addr(24'h000005);
        beat(4'h7); beat(4'h8); beat(4'h9);
        end_txn();

        for (int i = 0; i < 6; i++) begin
            read_txn(vecs[i].rom, vecs[i].addr, data, pre_oe, oe_and);
            check($sformatf("vec%0d data", i), {16'h0, data}, {16'h0, vecs[i].exp});
            check($sformatf("vec%0d oe pre", i), {28'h0, pre_oe}, 32'h0);
            check($sformatf("vec%0d oe data", i), {28'h0, oe_and}, 32'hF);
        end
        check("ram txn total", {16'h0, ram_cnt}, 32'd8);

        // Flash rejects a PSRAM command
        use_rom = 1'b1;
        send_single(8'h0B);
        end_txn();
        check("rom bad cmd err", {31'h0, rom_err}, 32'h1);
        check("rom txn total", {16'h0, rom_cnt}, 32'd5);

        // Reset in the middle of ADDR
        use_rom = 1'b0;
        send_quad(8'h0B);
        beat(4'h0); beat(4'h0); beat(4'h0);
        check("pre-abort quad", {31'h0, ram_quad}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort oe", {28'h0, ram_if.spi_data_oe}, 32'h0);
        check("abort quad", {31'h0, ram_quad}, 32'h0);
        check("abort status", {ram_cnt, 15'h0, ram_err}, 32'h0);
        rst = 1'b0;
        end_txn();
        check("abort no txn counted", {16'h0, ram_cnt}, 32'd0);

        // After reset the PSRAM is back in single-bit command mode
        send_single(8'h0B);
        end_txn();
        check("post-reset single cmd err", {31'h0, ram_err}, 32'h1);
        check("post-reset quad", {31'h0, ram_quad}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- QSPI target model: the responder end of the flash/PSRAM controller's bus, synthesizable and clocked by the same system clock.
- One SPI beat per `clk` cycle while select is low; this matches the controller, whose SPI clock is the inverted system clock, gated while active.
- Backed by an internal byte array. Emulates either the flash (EBh read) or PSRAM A (35h enter-quad, 0Bh quad read, 02h quad write).
- Used as an FPGA/bench-side target for closed-loop verification of the controller and for on-chip loopback tests.

Parameters:
- `IS_ROM`, 0: 0 = PSRAM personality, 1 = flash personality.
- `ADDR_BITS`, 24: width of the SPI address field.
- `MEM_BYTES`, 256: backing array depth (power of 2); the address is taken modulo `MEM_BYTES`.
- `PAGE_BYTES`, 32: burst wrap length used by `QSPI_RESP_BURST_WRAP_EN`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `spi_cs_n`  in  1  select, low = transaction active (flash or RAM A select).
- `spi_data_in`  in  4  controller's driven nibble; single-bit phases use bit 0.
- `spi_data_out`  out  4  responder nibble, registered.
- `spi_data_oe`  out  4  responder output enable, registered.
- `load_en`  in  1  backdoor byte write (ignored while `spi_cs_n` = 0).
- `load_addr`  in  `$clog2(MEM_BYTES)`  backdoor address.
- `load_data`  in  8  backdoor data.
- `quad_mode`  out  1  PSRAM is in quad command mode.
- `cmd_err`  out  1  sticky: unsupported command seen.
- `txn_count`  out  16  completed transactions, wraps at 0xFFFF.

Behaviour:
- **Reset** (`rst` = 1 at an edge):
  - state = IDLE; `spi_data_out` = 0, `spi_data_oe` = 0, `quad_mode` = 0, `cmd_err` = 0, `txn_count` = 0.
  - Memory is not cleared. Reset mid-transaction aborts immediately.
- **Beats:** beat k is the k-th rising edge with `spi_cs_n` = 0 since its falling edge. `spi_cs_n` = 1 at any edge forces IDLE, `oe` = 0.
- **Transaction count:** `txn_count` += 1 on the first `spi_cs_n` = 1 edge after at least one beat.
- **States:** IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- **CMD:**
  - Single-bit (8 beats, MSB first on bit 0) if `IS_ROM` = 1 or `quad_mode` = 0.
  - Otherwise quad (2 beats, high nibble first).
  - Decode happens on the last CMD beat:
    - ROM: EBh -> ADDR.
    - RAM single-bit: 35h -> `quad_mode` = 1, then IGNORE.
    - RAM quad: 0Bh -> ADDR (read); 02h -> ADDR (write).
    - Anything else -> `cmd_err` = 1, IGNORE.
- **ADDR:** `ADDR_BITS`/4 quad beats, MS nibble first, shifted into the address register.
- **DUMMY:** ROM 6 beats, RAM read 4 beats. RAM write skips DUMMY and goes straight to WDATA.
- **Read data:**
  - On the edge of the last DUMMY beat, register `spi_data_out` = mem[addr][7:4] and `oe` = 1111.
  - Each following RDATA beat alternates [3:0], then the next byte's [7:4]; addr += 1 after each low nibble.
  - This means the first data nibble is visible from the edge that ends DUMMY. It runs indefinitely until select goes high.
- **Write data:**
  - Each WDATA beat captures `spi_data_in`, high nibble first.
  - The byte is committed on its low-nibble beat; addr += 1.
  - A byte with only its high nibble received when select rises is discarded.
- **oe outside read:** `oe` = 0000 in every state except RDATA. The responder never drives during CMD, ADDR or WDATA.
- **IGNORE:** no drive, no memory access, until `spi_cs_n` = 1.
- **Address wrap:** linear mode wraps mod `MEM_BYTES` (0xFF -> 0x00 at default).
- **Backdoor load:** takes effect the edge it is sampled. Same-edge conflict with an SPI write is impossible because load is ignored while `spi_cs_n` = 0.
- **Quad mode persistence:** `quad_mode` is cleared only by `rst`; there is no exit command.
- **Flash personality:** no continuous-read/mode-bit handling; the EBh command is required on every transaction.

Optional Feature:
- Macro `QSPI_RESP_BURST_WRAP_EN`.
- **Defined:** the RDATA/WDATA address increment wraps within the aligned `PAGE_BYTES` block. With defaults, addr 0x1F -> 0x00 and 0x3F -> 0x20; the upper bits are held.
- **Undefined:** linear increment mod `MEM_BYTES` only.

Test Plan:
1. **Flash read:** `IS_ROM` = 1; backdoor mem[0x10..0x11] = A5, 3C. Send select low, EBh single, addr 000010, 6 dummy beats.
   -> `spi_data_out` A, 5, 3, C on consecutive beats; `oe` = 1111 only during data; `txn_count` = 1 after select rises.
2. **Enter quad then read:** `IS_ROM` = 0; send 35h single -> `quad_mode` = 1. Write 02h quad to addr 000040, nibbles 1, 2, 3, 4. Read 0Bh at 000040, 4 dummy beats.
   -> returns 1, 2, 3, 4; `oe` = 0 throughout the write.
3. **Bad command:** RAM with `quad_mode` = 1; quad command 9Fh, then 10 beats.
   -> `cmd_err` = 1, `oe` stays 0000, memory unchanged, `txn_count` increments.
4. **Partial write:** 02h to 000005, 3 data nibbles 7, 8, 9, then select high.
   -> mem[5] = 78, mem[6] unchanged.
5. **Wrap and abort:**
   - Linear: reading from 0xFF returns mem[0xFF] then mem[0x00].
   - With `QSPI_RESP_BURST_WRAP_EN`: reading from 0x1F returns mem[0x1F] then mem[0x00].
   - Assert `rst` during ADDR -> next edge state IDLE, `oe` = 0, `quad_mode` = 0.
